pov_column_sequencer: RTL and testbench

//  Rotation-locked column scheduler for the POV display. Measures the period between

---
 rtl/pov_column_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_pov_column_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pov_column_sequencer.sv
// Rotation-locked column scheduler: measures the index-to-index period, derives a
// per-column dwell and steps col_addr through one frame per revolution.
module pov_column_sequencer #(
    parameter int NUM_COLS  = 64,
    parameter int COL_W     = 6,
    parameter int PERIOD_W  = 24,
    parameter int MIN_DWELL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             index_in,
    output logic [COL_W-1:0] col_addr,
    output logic             col_valid,
    output logic             col_strobe,
    output logic             frame_done,
    output logic             speed_err
);

    localparam int DW = PERIOD_W + 1 - COL_W;
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(NUM_COLS - 1);
    // Smallest legal period: D >= MIN_DWELL is the same as P >= MIN_DWELL*NUM_COLS.
    localparam logic [PERIOD_W:0] P_MIN    = (PERIOD_W + 1)'(MIN_DWELL * NUM_COLS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_MEASURE,
        ST_RUN,
        ST_BLANK
    } state_t;

    state_t              state_q, state_d;
    logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [PERIOD_W-1:0] period_cnt_q, period_cnt_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [DW-1:0]       dwell_cnt_q, dwell_cnt_d;
    logic [COL_W-1:0]    col_addr_q, col_addr_d;
    logic                col_valid_q, col_valid_d;
    logic                col_strobe_q, col_strobe_d;
    logic                frame_done_q, frame_done_d;
    logic                speed_err_q, speed_err_d;

    logic                rise;
    logic                period_full;
    logic [PERIOD_W:0]   period_p;
    logic [DW-1:0]       new_dwell;
    logic                dwell_legal;
    logic                last_col_done;
    logic                start_frame;
    logic                fault;
    logic                stall;

    assign rise          = s2_q & ~s3_q;
    assign period_full   = &period_cnt_q;
    assign period_p      = {1'b0, period_cnt_q} + (PERIOD_W + 1)'(1);
    assign new_dwell     = period_p[PERIOD_W:COL_W];
    assign dwell_legal   = (period_p >= P_MIN);
    assign last_col_done = (state_q == ST_RUN) && (dwell_cnt_q == '0) && (col_addr_q == LAST_COL);

    always_comb begin
        state_d      = state_q;
        s1_d         = index_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        period_cnt_d = rise ? '0 : (period_full ? period_cnt_q : period_cnt_q + PERIOD_W'(1));
        dwell_d      = dwell_q;
        dwell_cnt_d  = dwell_cnt_q;
        col_addr_d   = col_addr_q;
        col_valid_d  = col_valid_q;
        col_strobe_d = 1'b0;
        frame_done_d = 1'b0;
        speed_err_d  = speed_err_q;
        start_frame  = 1'b0;
        fault        = 1'b0;
        stall        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                period_cnt_d = '0;
                state_d      = ST_SYNC;
            end
            ST_SYNC: begin
                if (rise) begin
                    state_d = ST_MEASURE;
                end else if (period_full) begin
                    stall = 1'b1;
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    if (dwell_legal) begin
                        start_frame = 1'b1;
                    end else begin
                        speed_err_d = 1'b1;
                    end
                end else if (period_full) begin
                    stall = 1'b1;
                end
            end
            ST_RUN: begin
                if (rise) begin
                    // A rise landing on the last column's final cycle still closes that frame.
                    frame_done_d = last_col_done;
                    start_frame  = dwell_legal;
                    fault        = ~dwell_legal;
                end else if (period_full) begin
                    stall = 1'b1;
                end else if (dwell_cnt_q != '0) begin
                    dwell_cnt_d = dwell_cnt_q - DW'(1);
                end else if (col_addr_q != LAST_COL) begin
                    col_addr_d   = col_addr_q + COL_W'(1);
                    col_strobe_d = 1'b1;
                    dwell_cnt_d  = dwell_q - DW'(1);
                end else begin
                    frame_done_d = 1'b1;
                    col_valid_d  = 1'b0;
                    state_d      = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (rise) begin
                    start_frame = dwell_legal;
                    fault       = ~dwell_legal;
                end else if (period_full) begin
                    stall = 1'b1;
                end
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        if (stall) begin
            state_d     = ST_SYNC;
            speed_err_d = 1'b1;
            col_valid_d = 1'b0;
        end
        if (fault) begin
            state_d     = ST_MEASURE;
            speed_err_d = 1'b1;
            col_valid_d = 1'b0;
        end
        if (start_frame) begin
            state_d      = ST_RUN;
            speed_err_d  = 1'b0;
            dwell_d      = new_dwell;
            dwell_cnt_d  = new_dwell - DW'(1);
            col_addr_d   = '0;
            col_valid_d  = 1'b1;
            col_strobe_d = 1'b1;
        end

        if (!enable) begin
            state_d      = ST_IDLE;
            period_cnt_d = '0;
            dwell_cnt_d  = '0;
            col_addr_d   = '0;
            col_valid_d  = 1'b0;
            col_strobe_d = 1'b0;
            frame_done_d = 1'b0;
            speed_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= enable ? ST_SYNC : ST_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            period_cnt_q <= '0;
            dwell_q      <= '0;
            dwell_cnt_q  <= '0;
            col_addr_q   <= '0;
            col_valid_q  <= 1'b0;
            col_strobe_q <= 1'b0;
            frame_done_q <= 1'b0;
            speed_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            period_cnt_q <= period_cnt_d;
            dwell_q      <= dwell_d;
            dwell_cnt_q  <= dwell_cnt_d;
            col_addr_q   <= col_addr_d;
            col_valid_q  <= col_valid_d;
            col_strobe_q <= col_strobe_d;
            frame_done_q <= frame_done_d;
            speed_err_q  <= speed_err_d;
        end
    end

    assign col_addr   = col_addr_q;
    assign col_valid  = col_valid_q;
    assign col_strobe = col_strobe_q;
    assign frame_done = frame_done_q;
    assign speed_err  = speed_err_q;

endmodule

// File: tb/tb_pov_column_sequencer.sv
// Directed bench for pov_column_sequencer with an 8-column, 8-bit-period configuration.
module tb_pov_column_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       index_in = 1'b0;
    logic [2:0] col_addr;
    logic       col_valid;
    logic       col_strobe;
    logic       frame_done;
    logic       speed_err;

    int errors = 0;
    int checks = 0;

    // Per-cycle capture of one index-to-index gap; entry j is sampled after the j-th edge
    // following the cycle in which index_in was raised. Column 0 appears at j=3.
    logic [2:0] lg_addr   [0:300];
    logic       lg_valid  [0:300];
    logic       lg_strobe [0:300];
    logic       lg_fd     [0:300];
    logic       lg_err    [0:300];

    pov_column_sequencer #(
        .NUM_COLS (8),
        .COL_W    (3),
        .PERIOD_W (8),
        .MIN_DWELL(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .index_in  (index_in),
        .col_addr  (col_addr),
        .col_valid (col_valid),
        .col_strobe(col_strobe),
        .frame_done(frame_done),
        .speed_err (speed_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs(input string tag, input logic [2:0] a, input logic v,
                               input logic s, input logic f, input logic e);
        chk({tag, "_addr"},   {29'b0, col_addr},   {29'b0, a});
        chk({tag, "_valid"},  {31'b0, col_valid},  {31'b0, v});
        chk({tag, "_strobe"}, {31'b0, col_strobe}, {31'b0, s});
        chk({tag, "_fd"},     {31'b0, frame_done}, {31'b0, f});
        chk({tag, "_err"},    {31'b0, speed_err},  {31'b0, e});
    endtask

    // Raise index for two cycles, then hold it low; log gap cycles.
    task automatic run_gap(input int gap);
        index_in = 1'b1;
        for (int j = 1; j <= gap; j++) begin
            step();
            if (j == 2) index_in = 1'b0;
            lg_addr[j]   = col_addr;
            lg_valid[j]  = col_valid;
            lg_strobe[j] = col_strobe;
            lg_fd[j]     = frame_done;
            lg_err[j]    = speed_err;
        end
        $display("gap %0d cycles: end addr=%0d valid=%0b err=%0b", gap, col_addr, col_valid, speed_err);
    endtask

    function automatic int count_strobes(input int lo, input int hi);
        int n = 0;
        for (int j = lo; j <= hi; j++) n += int'(lg_strobe[j]);
        return n;
    endfunction

    function automatic int count_fd(input int lo, input int hi);
        int n = 0;
        for (int j = lo; j <= hi; j++) n += int'(lg_fd[j]);
        return n;
    endfunction

    function automatic int count_valid(input int lo, input int hi);
        int n = 0;
        for (int j = lo; j <= hi; j++) n += int'(lg_valid[j]);
        return n;
    endfunction

    initial begin
        // Reset with index toggling
        rst = 1'b1;
        index_in = 1'b1; step(); chk_outputs("rst1", 3'd0, 0, 0, 0, 0);
        index_in = 1'b0; step(); chk_outputs("rst2", 3'd0, 0, 0, 0, 0);
        index_in = 1'b1; step(); chk_outputs("rst3", 3'd0, 0, 0, 0, 0);
        index_in = 1'b0;
        rst = 1'b0;
        repeat (5) step();
        chk_outputs("post_rst", 3'd0, 0, 0, 0, 0);

        // First rise only: still measuring, no column output
        run_gap(84);
        chk("g1_valid_cnt", count_valid(1, 84), 0);
        chk("g1_strobe_cnt", count_strobes(1, 84), 0);

        // Second rise: P=84 -> D=10
        run_gap(84);
        chk("g2_pre_valid", {31'b0, lg_valid[2]}, 0);
        chk("g2_c0_strobe", {31'b0, lg_strobe[3]}, 1);
        chk("g2_c0_valid", {31'b0, lg_valid[3]}, 1);
        chk("g2_c0_addr", {29'b0, lg_addr[3]}, 0);
        chk("g2_c0_hold", {31'b0, lg_strobe[4]}, 0);
        chk("g2_c1_strobe", {31'b0, lg_strobe[13]}, 1);
        chk("g2_c1_addr", {29'b0, lg_addr[13]}, 1);
        chk("g2_c1_early", {31'b0, lg_strobe[12]}, 0);
        chk("g2_c7_addr", {29'b0, lg_addr[73]}, 7);
        chk("g2_c7_strobe", {31'b0, lg_strobe[73]}, 1);
        chk("g2_strobe_cnt", count_strobes(1, 84), 8);
        chk("g2_last_valid", {31'b0, lg_valid[82]}, 1);
        chk("g2_fd_early", {31'b0, lg_fd[82]}, 0);
        chk("g2_fd", {31'b0, lg_fd[83]}, 1);
        chk("g2_blank_valid", {31'b0, lg_valid[83]}, 0);
        chk("g2_blank_addr", {29'b0, lg_addr[84]}, 7);
        chk("g2_fd_pulse", {31'b0, lg_fd[84]}, 0);

        // Third rise: steady, blank cycles continue until column 0
        run_gap(84);
        chk("g3_blank1", {31'b0, lg_valid[1]}, 0);
        chk("g3_blank2", {31'b0, lg_valid[2]}, 0);
        chk("g3_c0_strobe", {31'b0, lg_strobe[3]}, 1);
        chk("g3_c0_addr", {29'b0, lg_addr[3]}, 0);

        // Speed-up: this gap runs with D=10 but is cut short at 44
        run_gap(44);
        chk("g4_c4_addr", {29'b0, lg_addr[43]}, 4);
        chk("g4_c4_strobe", {31'b0, lg_strobe[43]}, 1);
        run_gap(80);
        chk("g5_trunc_valid", {31'b0, lg_valid[2]}, 1);
        chk("g5_trunc_addr", {29'b0, lg_addr[2]}, 4);
        chk("g5_restart_strobe", {31'b0, lg_strobe[3]}, 1);
        chk("g5_restart_addr", {29'b0, lg_addr[3]}, 0);
        chk("g5_no_fd", {31'b0, lg_fd[3]}, 0);
        chk("g5_d5_c1_addr", {29'b0, lg_addr[8]}, 1);
        chk("g5_d5_c1_strobe", {31'b0, lg_strobe[8]}, 1);
        chk("g5_fd", {31'b0, lg_fd[43]}, 1);
        chk("g5_fd_cnt", count_fd(1, 80), 1);

        // Exact fit: period 80 with D=10
        run_gap(80);
        chk("g6_c0_addr", {29'b0, lg_addr[3]}, 0);
        chk("g6_c7_strobe", {31'b0, lg_strobe[73]}, 1);
        chk("g6_fd_cnt", count_fd(4, 80), 0);
        run_gap(12);
        chk("g7_last_valid", {31'b0, lg_valid[2]}, 1);
        chk("g7_last_addr", {29'b0, lg_addr[2]}, 7);
        chk("g7_fit_fd", {31'b0, lg_fd[3]}, 1);
        chk("g7_fit_strobe", {31'b0, lg_strobe[3]}, 1);
        chk("g7_fit_addr", {29'b0, lg_addr[3]}, 0);
        chk("g7_fit_valid", {31'b0, lg_valid[3]}, 1);

        // Too fast: period 12 -> D=1
        run_gap(40);
        chk("g8_pre_err", {31'b0, lg_err[2]}, 0);
        chk("g8_err", {31'b0, lg_err[3]}, 1);
        chk("g8_err_valid", {31'b0, lg_valid[3]}, 0);
        chk("g8_err_strobe", {31'b0, lg_strobe[3]}, 0);
        chk("g8_valid_cnt", count_valid(3, 40), 0);

        // Period 40 recovers with D=5; then no index until the period saturates
        run_gap(300);
        chk("g9_err_clear", {31'b0, lg_err[3]}, 0);
        chk("g9_c0_strobe", {31'b0, lg_strobe[3]}, 1);
        chk("g9_c0_addr", {29'b0, lg_addr[3]}, 0);
        chk("g9_c1_addr", {29'b0, lg_addr[8]}, 1);
        chk("g9_fd", {31'b0, lg_fd[43]}, 1);
        chk("g9_pre_stall", {31'b0, lg_err[258]}, 0);
        chk("g9_stall_err", {31'b0, lg_err[259]}, 1);
        chk("g9_stall_valid", {31'b0, lg_valid[259]}, 0);

        // After stall: first rise only resynchronises, second rise runs
        run_gap(40);
        chk("g10_sync_valid", {31'b0, lg_valid[3]}, 0);
        chk("g10_sync_err", {31'b0, lg_err[3]}, 1);
        chk("g10_strobe_cnt", count_strobes(1, 40), 0);
        run_gap(40);
        chk("g11_c0_strobe", {31'b0, lg_strobe[3]}, 1);
        chk("g11_err", {31'b0, lg_err[3]}, 0);
        chk("g11_end_valid", {31'b0, lg_valid[40]}, 1);
        chk("g11_end_addr", {29'b0, lg_addr[40]}, 7);

        // Drop enable mid-RUN
        enable = 1'b0;
        step();
        chk_outputs("en_off", 3'd0, 0, 0, 0, 0);
        repeat (3) step();
        chk_outputs("en_off_hold", 3'd0, 0, 0, 0, 0);

        // Re-enable, relock, then reset mid-RUN
        enable = 1'b1;
        run_gap(40);
        chk("g12_strobe_cnt", count_strobes(1, 40), 0);
        run_gap(40);
        chk("g13_c0_strobe", {31'b0, lg_strobe[3]}, 1);
        chk("g13_valid", {31'b0, lg_valid[40]}, 1);
        rst = 1'b1;
        step();
        chk_outputs("mid_rst", 3'd0, 0, 0, 0, 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
